// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU with fixed WIDTH-iteration latency.
// Shift-add multiplier and restoring divider share one 2*WIDTH working register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CW = $clog2(WIDTH);

  muldiv_state_t      state;
  muldiv_op_t         op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] work;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     rem_full;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   result;
  logic               unused_rem_msb;

  // Multiply: work = {accumulator, remaining multiplier bits}, shifted right.
  // Divide:   work = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    hi        = work[2*WIDTH-1:WIDTH];
    lo        = work[WIDTH-1:0];
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, lo[WIDTH-1:1]};
    trial     = {hi, lo[WIDTH-1]};
    ge        = (trial >= {1'b0, opnd_q});
    rem_full  = trial - (ge ? {1'b0, opnd_q} : '0);
    div_next  = {rem_full[WIDTH-1:0], lo[WIDTH-2:0], ge};
    work_next = op_q[1] ? div_next : mul_next;
    result    = op_q[0] ? work_next[2*WIDTH-1:WIDTH] : work_next[WIDTH-1:0];
  end

  // The remainder never exceeds WIDTH bits after the conditional subtract.
  assign unused_rem_msb = rem_full[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      opnd_q <= '0;
      work   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= muldiv_op_t'(op);
            work   <= {{WIDTH{1'b0}}, (op[1] ? ain : bin)};
            opnd_q <= op[1] ? bin : ain;
            cnt    <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          work <= work_next;
          if (cnt == '0) begin
            dout  <= result;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed literals.
module tb_muldiv_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  // Reference model state
  bit           valid    = 1'b0;
  int unsigned  acc      = 0;
  logic [W-1:0] exp_res  = '0;
  logic [W-1:0] exp_dout = '0;
  bit           chk_en   = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .ain  (ain),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .dout (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_fn(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Model: an op accepted in cycle c is busy in c+1..c+W, done in c+W+1.
  always @(posedge clk) begin
    if (rst) begin
      valid    = 1'b0;
      exp_dout = '0;
    end else begin
      if (valid && cyc == acc + W) exp_dout = exp_res;
      if (start && !(valid && cyc >= acc + 1 && cyc <= acc + W)) begin
        valid   = 1'b1;
        acc     = cyc;
        exp_res = ref_fn(op, ain, bin);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, valid && cyc >= acc + 1 && cyc <= acc + W});
      check("done", {31'd0, done}, {31'd0, valid && cyc == acc + W + 1});
      check("dout", {16'd0, dout}, {16'd0, exp_dout});
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end
  end

  // Called at a negedge; raises start for one cycle and waits for done.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_lit, input logic [W-1:0] lit, input bit mid_start);
    int unsigned c;
    int unsigned bc;
    bit          got;
    start = 1'b1; op = o; ain = a; bin = b;
    c  = cyc;
    bc = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ain = W'($urandom); bin = W'($urandom); op = 2'($urandom);
    for (int k = 0; k < 40; k++) begin
      start = (mid_start && cyc == c + 5);
      if (start) begin ain = W'($urandom); bin = W'($urandom); end
      if (done) begin got = 1'b1; break; end
      if (busy) bc++;
      @(negedge clk);
    end
    check("op_timeout", {31'd0, got}, 32'd1);
    check("latency", cyc - c, 32'd17);
    check("busy_cycles", bc, 32'd16);
    check("result", {16'd0, dout}, {16'd0, use_lit ? lit : ref_fn(o, a, b)});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    rst = 1'b1; start = 1'b0; op = '0; ain = '0; bin = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; op = 2'b00; ain = 16'h0003; bin = 16'h0003;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    do_op(2'b00, 16'h1234, 16'h0010, 1'b1, 16'h2340, 1'b0);
    @(negedge clk);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b0);
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b0);  // back-to-back
    @(negedge clk);
    do_op(2'b10, 16'd100, 16'd7, 1'b1, 16'd14, 1'b0);
    do_op(2'b11, 16'd100, 16'd7, 1'b1, 16'd2, 1'b0);
    do_op(2'b10, 16'h0005, 16'h0009, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    do_op(2'b10, 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
    do_op(2'b11, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0);
    @(negedge clk);
    do_op(2'b00, 16'h1234, 16'h0010, 1'b1, 16'h2340, 1'b1);  // start pulsed mid-RUN
    @(negedge clk);

    // Reset in RUN cycle 5 aborts the op.
    start = 1'b1; op = 2'b01; ain = 16'hABCD; bin = 16'h1357;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dout", {16'd0, dout}, 32'd0);
    repeat (25) @(negedge clk);
    do_op(2'b11, 16'd1000, 16'd33, 1'b1, 16'd10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      o = 2'($urandom);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op(o, a, b, 1'b0, '0, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
